// File: rtl/dma_pattern_pkg.sv
// Shared types and constants for the DMA pattern source.
package dma_pattern_pkg;

  typedef enum logic [1:0] {
    MODE_COUNT = 2'd0,
    MODE_RNG   = 2'd1,
    MODE_CONST = 2'd2,
    MODE_WALK  = 2'd3
  } dma_mode_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } dma_state_t;

  localparam int unsigned DATA_W = 64;
  localparam int unsigned CPU_W  = 32;

  localparam int unsigned REG_CTRL   = 0;
  localparam int unsigned REG_LEN    = 1;
  localparam int unsigned REG_SEED   = 2;
  localparam int unsigned REG_CYCLES = 3;

  localparam int unsigned CTRL_START_BIT = 0;
  localparam int unsigned CTRL_ABORT_BIT = 1;
  localparam int unsigned CTRL_MODE_LSB  = 2;

  localparam int unsigned STAT_BUSY_BIT    = 0;
  localparam int unsigned STAT_DONE_BIT    = 1;
  localparam int unsigned STAT_ABORTED_BIT = 2;
  localparam int unsigned STAT_MODE_LSB    = 4;

  // Single set bit at the given position of a 64-bit word.
  function automatic logic [DATA_W-1:0] walk_word(input logic [5:0] pos);
    return 64'd1 << pos;
  endfunction

endpackage

// File: rtl/dma_pattern_ctrl_if.sv
// DMA output stream plus upstream RNG stream, grouped for benches and wrappers.
interface dma_pattern_ctrl_if;
  import dma_pattern_pkg::*;

  logic [DATA_W-1:0] dma_data;
  logic              dma_valid;
  logic              dma_ready;
  logic [DATA_W-1:0] rng_data;
  logic              rng_valid;
  logic              rng_ready;
  logic              rng_reset;

  modport master (
    output dma_data, dma_valid, rng_ready, rng_reset,
    input  dma_ready, rng_data, rng_valid
  );

  modport slave (
    input  dma_data, dma_valid, rng_ready, rng_reset,
    output dma_ready, rng_data, rng_valid
  );
endinterface

// File: rtl/dma_word_gen.sv
// Word index counter and per-mode pattern mux for the DMA pattern source.
module dma_word_gen
  import dma_pattern_pkg::*;
#(
  parameter int unsigned LEN_BITS = 16
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_load,
  input  logic                i_advance,
  input  dma_mode_t           i_mode,
  input  logic [CPU_W-1:0]    i_seed,
  input  logic [DATA_W-1:0]   i_rng_data,
  output logic [DATA_W-1:0]   o_data,
  output logic [LEN_BITS-1:0] o_index
);

  logic [LEN_BITS-1:0] r_index;
  logic [CPU_W-1:0]    w_index32;
  logic [5:0]          w_walk_pos;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_index <= '0;
    end else if (i_load) begin
      r_index <= '0;
    end else if (i_advance) begin
      r_index <= r_index + LEN_BITS'(1);
    end
  end

  assign w_index32  = 32'(r_index);
  assign w_walk_pos = w_index32[5:0];
  assign o_index    = r_index;

  // Data only moves with the index, so it holds through stalls.
  always_comb begin
    o_data = '0;
    case (i_mode)
      MODE_COUNT: o_data = {i_seed, w_index32};
      MODE_RNG:   o_data = i_rng_data;
      MODE_CONST: o_data = {i_seed, i_seed};
      MODE_WALK:  o_data = walk_word(w_walk_pos);
      default:    o_data = '0;
    endcase
  end

endmodule

// File: rtl/dma_pattern_ctrl.sv
// Register-programmable DMA pattern source (count / RNG / const / walking-one).
// Define DMA_CYCLE_COUNT_EN to implement the elapsed-cycle register.
module dma_pattern_ctrl
  import dma_pattern_pkg::*;
#(
  parameter int unsigned REG_ABITS = 2,
  parameter int unsigned LEN_BITS  = 16
) (
  input  logic                 pcieClk_in,
  input  logic                 reset_in,
  input  logic [REG_ABITS-1:0] cpuChan_in,
  input  logic [CPU_W-1:0]     cpuWrData_in,
  input  logic                 cpuWrValid_in,
  output logic                 cpuWrReady_out,
  output logic [CPU_W-1:0]     cpuRdData_out,
  output logic                 cpuRdValid_out,
  input  logic                 cpuRdReady_in,
  input  logic [DATA_W-1:0]    rngData_in,
  input  logic                 rngValid_in,
  output logic                 rngReady_out,
  output logic                 rngReset_out,
  output logic [DATA_W-1:0]    dmaData_out,
  output logic                 dmaValid_out,
  input  logic                 dmaReady_in
);

  dma_state_t          r_state;
  dma_mode_t           r_mode;
  logic [LEN_BITS-1:0] r_len;
  logic [CPU_W-1:0]    r_seed;
  logic                r_done;
  logic                r_aborted;

  logic [CPU_W-1:0]    w_chan32;
  logic                w_wr_ctrl;
  logic                w_wr_len;
  logic                w_wr_seed;
  logic                w_start;
  logic                w_abort;
  dma_mode_t           w_wr_mode;
  logic                w_idle;
  logic                w_run;
  logic                w_len_nz;
  logic                w_launch;
  logic                w_rng_mode;
  logic                w_xfer;
  logic                w_last;
  logic [LEN_BITS-1:0] w_index;
  logic [CPU_W-1:0]    w_cycles_rd;
  logic [CPU_W-1:0]    w_rd_data;
  logic                w_unused;

  assign w_chan32  = 32'(cpuChan_in);
  assign w_wr_ctrl = cpuWrValid_in && (w_chan32 == REG_CTRL);
  assign w_wr_len  = cpuWrValid_in && (w_chan32 == REG_LEN);
  assign w_wr_seed = cpuWrValid_in && (w_chan32 == REG_SEED);
  // ABORT in the same write suppresses START.
  assign w_start   = w_wr_ctrl && cpuWrData_in[CTRL_START_BIT] && !cpuWrData_in[CTRL_ABORT_BIT];
  assign w_abort   = w_wr_ctrl && cpuWrData_in[CTRL_ABORT_BIT];
  assign w_wr_mode = dma_mode_t'(cpuWrData_in[CTRL_MODE_LSB +: 2]);

  assign w_idle     = (r_state == ST_IDLE);
  assign w_run      = (r_state == ST_RUN);
  assign w_len_nz   = (r_len != '0);
  assign w_launch   = w_idle && w_start && w_len_nz;
  assign w_rng_mode = (r_mode == MODE_RNG);

  assign dmaValid_out = w_run && (!w_rng_mode || rngValid_in);
  assign rngReady_out = w_run && w_rng_mode && dmaReady_in;
  assign rngReset_out = w_launch && (w_wr_mode == MODE_RNG);
  assign w_xfer       = dmaValid_out && dmaReady_in;
  assign w_last       = w_xfer && (w_index == (r_len - LEN_BITS'(1)));

  assign cpuWrReady_out = 1'b1;
  assign cpuRdValid_out = 1'b1;
  assign w_unused       = cpuRdReady_in;

  // Control FSM and programming registers; config is frozen while running.
  always_ff @(posedge pcieClk_in) begin
    if (reset_in) begin
      r_state   <= ST_IDLE;
      r_mode    <= MODE_COUNT;
      r_len     <= '0;
      r_seed    <= '0;
      r_done    <= 1'b0;
      r_aborted <= 1'b0;
    end else if (w_idle) begin
      if (w_wr_len)  r_len  <= cpuWrData_in[LEN_BITS-1:0];
      if (w_wr_seed) r_seed <= cpuWrData_in;
      if (w_wr_ctrl) r_mode <= w_wr_mode;
      if (w_start) begin
        r_aborted <= 1'b0;
        if (w_len_nz) begin
          r_state <= ST_RUN;
          r_done  <= 1'b0;
        end else begin
          r_done  <= 1'b1;
        end
      end
    end else begin
      if (w_abort) begin
        r_state   <= ST_IDLE;
        r_aborted <= 1'b1;
        r_done    <= 1'b0;
      end else if (w_last) begin
        r_state <= ST_IDLE;
        r_done  <= 1'b1;
      end
    end
  end

  dma_word_gen #(
    .LEN_BITS (LEN_BITS)
  ) u_word_gen (
    .i_clk      (pcieClk_in),
    .i_rst      (reset_in),
    .i_load     (w_launch),
    .i_advance  (w_xfer),
    .i_mode     (r_mode),
    .i_seed     (r_seed),
    .i_rng_data (rngData_in),
    .o_data     (dmaData_out),
    .o_index    (w_index)
  );

`ifdef DMA_CYCLE_COUNT_EN
  logic [CPU_W-1:0] r_cycles;
  logic             w_wr_cycles;

  assign w_wr_cycles = cpuWrValid_in && (w_chan32 == REG_CYCLES);

  // Saturating count of RUN cycles; CPU write or a new burst clears it.
  always_ff @(posedge pcieClk_in) begin
    if (reset_in) begin
      r_cycles <= '0;
    end else if (w_wr_cycles || w_launch) begin
      r_cycles <= '0;
    end else if (w_run && (r_cycles != '1)) begin
      r_cycles <= r_cycles + 32'd1;
    end
  end

  assign w_cycles_rd = r_cycles;
`else
  assign w_cycles_rd = '0;
`endif

  always_comb begin
    w_rd_data = '0;
    case (w_chan32)
      REG_CTRL: begin
        w_rd_data[STAT_BUSY_BIT]          = w_run;
        w_rd_data[STAT_DONE_BIT]          = r_done;
        w_rd_data[STAT_ABORTED_BIT]       = r_aborted;
        w_rd_data[STAT_MODE_LSB +: 2]     = r_mode;
      end
      REG_LEN:    w_rd_data = 32'(r_len);
      REG_SEED:   w_rd_data = r_seed;
      REG_CYCLES: w_rd_data = w_cycles_rd;
      default:    w_rd_data = '0;
    endcase
  end

  assign cpuRdData_out = w_rd_data;

endmodule

// File: tb/tb_dma_pattern_ctrl.sv
// Directed + randomized bench for dma_pattern_ctrl against a word-list reference model.
module tb_dma_pattern_ctrl;
  import dma_pattern_pkg::*;

  localparam int unsigned LEN_BITS = 16;
  localparam int          BUDGET   = 400;

  logic        clk = 1'b0;
  logic        reset_in;
  logic [1:0]  chan;
  logic [31:0] wdata;
  logic        wvalid;
  logic        wr_ready;
  logic [31:0] rd_out;
  logic        rd_valid;

  dma_pattern_ctrl_if bus();

  always #4 clk = ~clk;

  dma_pattern_ctrl #(.REG_ABITS(2), .LEN_BITS(LEN_BITS)) dut (
    .pcieClk_in     (clk),
    .reset_in       (reset_in),
    .cpuChan_in     (chan),
    .cpuWrData_in   (wdata),
    .cpuWrValid_in  (wvalid),
    .cpuWrReady_out (wr_ready),
    .cpuRdData_out  (rd_out),
    .cpuRdValid_out (rd_valid),
    .cpuRdReady_in  (1'b1),
    .rngData_in     (bus.rng_data),
    .rngValid_in    (bus.rng_valid),
    .rngReady_out   (bus.rng_ready),
    .rngReset_out   (bus.rng_reset),
    .dmaData_out    (bus.dma_data),
    .dmaValid_out   (bus.dma_valid),
    .dmaReady_in    (bus.dma_ready)
  );

  int          total = 0;
  int          bad   = 0;
  logic [63:0] exp_q[$];
  logic [63:0] rng_seq[64];
  int          rng_idx;
  int          n_rng_rst;
  int          n_xfer;
  int          n_valid;
  logic        stall_prev;
  logic [63:0] held;
  logic        last_valid;
  logic        last_rng_ready;
  logic        last_rng_reset;
  logic        rng_xfer;
  logic [31:0] rd_data;
  dma_mode_t   cur_mode;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Word i of a burst, straight from the mode definitions.
  function automatic logic [63:0] model_word(dma_mode_t m, logic [31:0] seed, int i);
    logic [63:0] one = 64'd1;
    case (m)
      MODE_COUNT: return {seed, 32'(i)};
      MODE_CONST: return {seed, seed};
      MODE_WALK:  return one << (i % 64);
      default:    return rng_seq[i % 64];
    endcase
  endfunction

  // One clock: sample at negedge, then advance inputs just after posedge.
  task automatic cyc();
    @(negedge clk);
    rd_data        = rd_out;
    last_valid     = bus.dma_valid;
    last_rng_ready = bus.rng_ready;
    last_rng_reset = bus.rng_reset;
    rng_xfer       = bus.rng_valid && bus.rng_ready;
    if (bus.rng_reset) n_rng_rst++;
    if (bus.dma_valid) n_valid++;
    if (stall_prev) begin
      chk("hold_valid", 64'(bus.dma_valid), 64'd1);
      chk("hold_data", bus.dma_data, held);
    end
    stall_prev = bus.dma_valid && !bus.dma_ready;
    held       = bus.dma_data;
    if (bus.dma_valid && bus.dma_ready) begin
      total++;
      assert (exp_q.size() != 0) else begin
        bad++;
        $error("FAIL extra_word observed=0x%0h expected=no transfer", bus.dma_data);
      end
      if (exp_q.size() != 0) chk("word", bus.dma_data, exp_q.pop_front());
      n_xfer++;
    end
    if (cur_mode != MODE_RNG) chk("rng_ready_idle", 64'(bus.rng_ready), 64'd0);
    @(posedge clk);
    #1;
    wvalid = 1'b0;
    if (last_rng_reset) begin
      rng_idx       = 0;
      bus.rng_valid = 1'b0;
    end else begin
      if (rng_xfer) rng_idx++;
      if (rng_xfer || !bus.rng_valid) bus.rng_valid = 1'($urandom_range(0, 1));
    end
    bus.rng_data = rng_seq[rng_idx % 64];
  endtask

  task automatic cpu_wr(input int unsigned ch, input logic [31:0] d);
    chan   = 2'(ch);
    wdata  = d;
    wvalid = 1'b1;
    cyc();
  endtask

  task automatic cpu_rd(input int unsigned ch, output logic [31:0] d);
    chan = 2'(ch);
    cyc();
    d = rd_data;
  endtask

  // Program and run one burst; rpol 0=ready high, 1=alternate from 0, 2=random.
  task automatic run_burst(input dma_mode_t m, input logic [31:0] seed, input int len,
                           input int rpol, input int abort_at, input bit poke);
    int          k;
    bit          finished;
    bit          abort_now;
    logic [31:0] v;
    logic [31:0] exp_ctrl;
    cpu_wr(REG_LEN, 32'(len));
    cpu_wr(REG_SEED, seed);
    if (m == MODE_RNG) for (int j = 0; j < 64; j++) rng_seq[j] = {$urandom, $urandom};
    cur_mode = m;
    exp_q.delete();
    for (int i = 0; i < len; i++) exp_q.push_back(model_word(m, seed, i));
    n_rng_rst = 0;
    n_xfer    = 0;
    cpu_wr(REG_CTRL, 32'({m, 2'b01}));
    k = 0; finished = 1'b0; abort_now = 1'b0;
    while (k < BUDGET) begin
      case (rpol)
        0:       bus.dma_ready = 1'b1;
        1:       bus.dma_ready = 1'(k % 2);
        default: bus.dma_ready = 1'($urandom_range(0, 1));
      endcase
      if (poke && k == 0) begin
        chan = 2'(REG_LEN); wdata = 32'd7; wvalid = 1'b1;
      end else if (poke && k == 1) begin
        chan = 2'(REG_CTRL); wdata = 32'hC; wvalid = 1'b1;
      end else if (abort_at != 0 && n_xfer == abort_at) begin
        chan = 2'(REG_CTRL); wdata = 32'h2; wvalid = 1'b1; abort_now = 1'b1;
      end
      cyc();
      k++;
      if (k == 1 && m != MODE_RNG) chk("first_valid", 64'(last_valid), 64'd1);
      if (abort_now || exp_q.size() == 0) begin
        finished = 1'b1;
        break;
      end
    end
    total++;
    assert (finished) else begin
      bad++;
      $error("FAIL burst_timeout observed=%0d words left expected=0", exp_q.size());
    end
    if (abort_now) begin
      exp_q.delete();
      stall_prev = 1'b0;
      exp_ctrl   = 32'h4 | 32'({m, 4'b0});
    end else begin
      exp_ctrl   = 32'h2 | 32'({m, 4'b0});
    end
    chan = 2'(REG_CTRL);
    bus.dma_ready = 1'b1;
    cyc();
    chk("valid_after_end", 64'(last_valid), 64'd0);
    chk("ctrl_status", 64'(rd_data), 64'(exp_ctrl));
    cpu_rd(REG_CYCLES, v);
`ifdef DMA_CYCLE_COUNT_EN
    chk("cycles", 64'(v), 64'(k));
`else
    chk("cycles_absent", 64'(v), 64'd0);
`endif
    cpu_rd(REG_LEN, v);
    chk("len_readback", 64'(v), 64'(len));
    chk("rng_reset_pulses", 64'(n_rng_rst), (m == MODE_RNG) ? 64'd1 : 64'd0);
  endtask

  initial begin
    logic [31:0] v;
    reset_in = 1'b1; chan = '0; wdata = '0; wvalid = 1'b0;
    bus.dma_ready = 1'b0; bus.rng_valid = 1'b0;
    for (int j = 0; j < 64; j++) rng_seq[j] = {$urandom, $urandom};
    bus.rng_data = rng_seq[0];
    rng_idx = 0; n_rng_rst = 0; n_xfer = 0; n_valid = 0;
    stall_prev = 1'b0; held = '0; cur_mode = MODE_COUNT;
    #1;
    repeat (3) cyc();
    reset_in = 1'b0;

    // Reset state.
    for (int r = 0; r < 4; r++) begin
      cpu_rd(r, v);
      chk("reset_reg", 64'(v), 64'd0);
    end
    chk("reset_valid", 64'(last_valid), 64'd0);
    chk("reset_rng_ready", 64'(last_rng_ready), 64'd0);
    chk("reset_rng_reset", 64'(last_rng_reset), 64'd0);
    chk("wr_ready_tied", 64'(wr_ready), 64'd1);
    chk("rd_valid_tied", 64'(rd_valid), 64'd1);

    // COUNT burst, ready high; then CYCLES clear-on-write.
    run_burst(MODE_COUNT, 32'hCAFE0000, 4, 0, 0, 1'b0);
    cpu_wr(REG_CYCLES, 32'h1234);
    cpu_rd(REG_CYCLES, v);
    chk("cycles_cleared", 64'(v), 64'd0);

    // Same burst with alternating ready and config writes while busy.
    run_burst(MODE_COUNT, 32'hCAFE0000, 4, 1, 0, 1'b1);

    // Walking one across the 64-bit wrap.
    run_burst(MODE_WALK, 32'h0, 66, 0, 0, 1'b0);

    // ABORT after two transfers, then START+ABORT while idle.
    run_burst(MODE_COUNT, 32'h5A5A0000, 10, 0, 2, 1'b0);
    cpu_wr(REG_CTRL, 32'h3);
    chan = 2'(REG_CTRL);
    n_valid = 0;
    repeat (3) cyc();
    chk("start_abort_no_valid", 64'(n_valid), 64'd0);
    chk("start_abort_ctrl", 64'(rd_data), 64'h4);

    // START with LEN=0.
    cpu_wr(REG_LEN, 32'd0);
    cpu_wr(REG_CTRL, 32'h1);
    chan = 2'(REG_CTRL);
    n_valid = 0;
    repeat (5) cyc();
    chk("len0_no_valid", 64'(n_valid), 64'd0);
    chk("len0_ctrl", 64'(rd_data), 64'h2);

    // RNG burst of 3 words.
    run_burst(MODE_RNG, 32'h0, 3, 0, 0, 1'b0);
    n_valid = 0;
    repeat (4) cyc();
    chk("rng_after_no_valid", 64'(n_valid), 64'd0);
    chk("rng_after_ready", 64'(last_rng_ready), 64'd0);
    cur_mode = MODE_COUNT;

    // Reset mid-burst.
    cpu_wr(REG_LEN, 32'd20);
    cpu_wr(REG_SEED, 32'h0BAD0000);
    exp_q.delete();
    for (int i = 0; i < 20; i++) exp_q.push_back(model_word(MODE_COUNT, 32'h0BAD0000, i));
    cpu_wr(REG_CTRL, 32'h1);
    bus.dma_ready = 1'b1;
    repeat (3) cyc();
    bus.dma_ready = 1'b0;
    reset_in = 1'b1;
    cyc();
    reset_in = 1'b0;
    stall_prev = 1'b0;
    exp_q.delete();
    bus.dma_ready = 1'b1;
    n_valid = 0;
    repeat (3) cyc();
    chk("post_reset_no_valid", 64'(n_valid), 64'd0);
    for (int r = 0; r < 4; r++) begin
      cpu_rd(r, v);
      chk("post_reset_reg", 64'(v), 64'd0);
    end

    // Randomized bursts with random ready.
    for (int t = 0; t < 8; t++) begin
      run_burst(dma_mode_t'($urandom_range(0, 3)), $urandom, int'($urandom_range(1, 24)),
                2, 0, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
